// File: rtl/key_scan4_pkg.sv
// -----------------------------------------------------------------------------
// key_scan4_pkg
// Shared definitions for the four-key scanner front end.
//   NKEY            : number of push-button channels
//   CNT_MAX_DEFAULT : debounce length in cycles for silicon (20 ms at 100 MHz)
//   CNT_MAX_SIM     : short debounce length used in simulation
//   key_vec_t       : one bit per key
//   keep_highest()  : reduces a key vector to its highest-index set bit
// -----------------------------------------------------------------------------
package key_scan4_pkg;

  localparam int NKEY            = 4;
  localparam int CNT_MAX_DEFAULT = 2_000_000;
  localparam int CNT_MAX_SIM     = 4;

  typedef logic [NKEY-1:0] key_vec_t;

  // Priority 3 > 2 > 1 > 0: the last set bit visited wins, so the result is
  // always zero or exactly one-hot.
  function automatic key_vec_t keep_highest(input key_vec_t v);
    key_vec_t r;
    r = '0;
    for (int i = 0; i < NKEY; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Single push-button channel: two-flop synchroniser, counter debounce and
// rising-edge detect of the debounced level.
//   clk   : system clock, posedge
//   rst   : synchronous active-high reset
//   raw   : asynchronous button level, 1 = pressed
//   level : debounced stable level (registered)
//   rise  : high for the one cycle after level goes 0 -> 1
// CNT_MAX must be at least 2.
// -----------------------------------------------------------------------------
module key_debounce
  import key_scan4_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int               CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             stable_d;

  // Stage p0/p1: synchronise the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage debounce: a new level is accepted only after CNT_MAX consecutive
  // samples disagree with the current one; any agreeing sample restarts the
  // run, so the counter stops at CNT_MAX-1 and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_d;

endmodule

// File: rtl/key_scan4.sv
// -----------------------------------------------------------------------------
// key_scan4
// Four-button front end for the one-hot-to-binary encoder. Each key is
// synchronised, debounced and edge-detected independently; the most recently
// pressed key is held as a one-hot code with a one-cycle strobe.
//   clk        : system clock, posedge
//   rst        : synchronous active-high reset
//   key_raw    : asynchronous button levels, 1 = pressed
//   clr        : synchronous clear of the held key
//   key_level  : debounced level per key
//   key_onehot : held one-hot of the last pressed key, 0000 = none; never
//                more than one bit set, so the encoder default is unreachable
//   key_pulse  : high for one cycle when key_onehot is updated by a press
// CNT_MAX must be at least 2.
// -----------------------------------------------------------------------------
module key_scan4
  import key_scan4_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_raw,
  input  logic            clr,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_onehot,
  output logic            key_pulse
);

  key_vec_t rise;

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    key_debounce #(
      .CNT_MAX (CNT_MAX)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_raw[i]),
      .level (key_level[i]),
      .rise  (rise[i])
    );
  end

  // Stage latch: a press always wins over a simultaneous clear; releases
  // only show up on key_level.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_onehot <= '0;
      key_pulse  <= 1'b0;
    end else if (|rise) begin
      key_onehot <= keep_highest(rise);
      key_pulse  <= 1'b1;
    end else begin
      if (clr) begin
        key_onehot <= '0;
      end
      key_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_scan4.sv
module tb_key_scan4;
  import key_scan4_pkg::*;

  localparam int CM = CNT_MAX_SIM;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] key_raw;
  logic [3:0] key_level;
  logic [3:0] key_onehot;
  logic       key_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_scan4 #(.CNT_MAX(CM)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .clr        (clr),
    .key_level  (key_level),
    .key_onehot (key_onehot),
    .key_pulse  (key_pulse)
  );

  // Reference model: a key's level flips once the last CM synchronised
  // samples all disagree with it; a press is reported on the edge after the
  // level goes high, highest index first.
  logic [3:0] m_s1, m_s2, m_level, m_press, m_onehot;
  logic       m_pulse;
  logic [3:0] hist [CM];

  always @(posedge clk) begin
    logic [3:0] nxt;
    logic       flip;
    int         idx;
    logic [3:0] one;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_onehot = 0; m_pulse = 0;
      for (int j = 0; j < CM; j++) hist[j] = 4'b0;
    end else begin
      for (int j = CM - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = m_s2;
      nxt = m_level;
      for (int k = 0; k < 4; k++) begin
        flip = 1'b1;
        for (int j = 0; j < CM; j++) if (hist[j][k] == m_level[k]) flip = 1'b0;
        if (flip) nxt[k] = ~m_level[k];
      end
      if (m_press != 0) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (m_press[k]) idx = k;
        one = 4'b0001;
        m_onehot = one << idx;
        m_pulse = 1'b1;
      end else begin
        if (clr) m_onehot = 4'b0;
        m_pulse = 1'b0;
      end
      m_press = nxt & ~m_level;
      m_level = nxt;
      m_s2 = m_s1;
      m_s1 = key_raw;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle(input string name, input int n);
    key_raw = 4'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
        errors++;
        $display("FAIL %s_settle: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b", name,
                 key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
      end
    end
  endtask

  task automatic test_reset();
    int np;
    rst = 1'b1; clr = 1'b0; key_raw = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({key_level, key_onehot, key_pulse} !== 9'b0) begin
        errors++;
        $display("FAIL reset_hold: got lvl=%b oh=%b p=%b want all zero",
                 key_level, key_onehot, key_pulse);
      end
    end
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (key_pulse === 1'b1) np++;
      checks++;
      if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
        errors++;
        $display("FAIL reset_release: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b",
                 key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
      end
    end
    checks++;
    if (np != 1) begin errors++; $display("FAIL reset_pulses: got %0d want 1", np); end
    checks++;
    if (key_onehot !== 4'b1000) begin
      errors++; $display("FAIL reset_onehot: got %b want 1000", key_onehot);
    end
    settle("reset", 10);
  endtask

  task automatic test_clean_press();
    key_raw = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
        errors++;
        $display("FAIL press_model c=%0d: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b", c,
                 key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
      end
      if (c == 4) begin
        checks++;
        if (key_level !== 4'b0000) begin
          errors++; $display("FAIL press_level_early: got %b want 0000", key_level);
        end
      end
      if (c == 5) begin
        checks++;
        if ({key_level, key_pulse} !== {4'b0010, 1'b0}) begin
          errors++; $display("FAIL press_level: got lvl=%b p=%b want 0010 0", key_level, key_pulse);
        end
      end
      if (c == 6) begin
        checks++;
        if ({key_onehot, key_pulse} !== {4'b0010, 1'b1}) begin
          errors++; $display("FAIL press_latch: got oh=%b p=%b want 0010 1", key_onehot, key_pulse);
        end
      end
      if (c == 7) begin
        checks++;
        if (key_pulse !== 1'b0) begin
          errors++; $display("FAIL press_pulse_end: got %b want 0", key_pulse);
        end
      end
    end
    settle("press", 10);
  endtask

  task automatic test_bounce();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (key_onehot !== 4'b0000) begin
      errors++; $display("FAIL bounce_preclear: got %b want 0000", key_onehot);
    end
    for (int i = 0; i < 20; i++) begin
      key_raw = (i < 10 && (i % 2) == 0) ? 4'b0100 : 4'b0000;
      tick();
      checks++;
      if ({key_level, key_onehot, key_pulse} !== 9'b0 ||
          {m_level, m_onehot, m_pulse} !== 9'b0) begin
        errors++;
        $display("FAIL bounce i=%0d: got lvl=%b oh=%b p=%b want all zero", i,
                 key_level, key_onehot, key_pulse);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] pats [2];
    logic [3:0] want [2];
    int np;
    pats[0] = 4'b1001; want[0] = 4'b1000;
    pats[1] = 4'b0101; want[1] = 4'b0100;
    for (int p = 0; p < 2; p++) begin
      key_raw = pats[p];
      np = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (key_pulse === 1'b1) np++;
        checks++;
        if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
          errors++;
          $display("FAIL simul_model p=%0d: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b", p,
                   key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
        end
      end
      checks++;
      if (np != 1 || key_onehot !== want[p] || key_level !== pats[p]) begin
        errors++;
        $display("FAIL simul_result p=%0d: got pulses=%0d oh=%b lvl=%b want 1 %b %b", p,
                 np, key_onehot, key_level, want[p], pats[p]);
      end
    end
    settle("simul", 10);
  endtask

  task automatic test_clr_vs_press();
    key_raw = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
        errors++;
        $display("FAIL clrpress_model c=%0d: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b", c,
                 key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
      end
      if (c == 5) clr = 1'b1;
      if (c == 6) begin
        checks++;
        if ({key_onehot, key_pulse} !== {4'b0010, 1'b1}) begin
          errors++; $display("FAIL press_beats_clr: got oh=%b p=%b want 0010 1", key_onehot, key_pulse);
        end
      end
      if (c == 7) begin
        clr = 1'b0;
        checks++;
        if ({key_onehot, key_pulse} !== {4'b0000, 1'b0}) begin
          errors++; $display("FAIL clr_after: got oh=%b p=%b want 0000 0", key_onehot, key_pulse);
        end
      end
    end
    settle("clrpress", 10);
  endtask

  task automatic test_repress();
    logic [3:0] pats [3];
    int         wantp [3];
    int np;
    pats[0] = 4'b0001; wantp[0] = 1;
    pats[1] = 4'b0000; wantp[1] = 0;
    pats[2] = 4'b0001; wantp[2] = 1;
    for (int p = 0; p < 3; p++) begin
      key_raw = pats[p];
      np = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (key_pulse === 1'b1) np++;
        checks++;
        if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
          errors++;
          $display("FAIL repress_model p=%0d: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b", p,
                   key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
        end
      end
      checks++;
      if (np != wantp[p] || key_onehot !== 4'b0001 || key_level !== pats[p]) begin
        errors++;
        $display("FAIL repress_result p=%0d: got pulses=%0d oh=%b lvl=%b want %0d 0001 %b", p,
                 np, key_onehot, key_level, wantp[p], pats[p]);
      end
    end
    settle("repress", 10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 5) == 0) key_raw[$urandom_range(0, 3)] ^= 1'b1;
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      tick();
      checks++;
      if ({key_level, key_onehot, key_pulse} !== {m_level, m_onehot, m_pulse}) begin
        errors++;
        $display("FAIL random_model i=%0d: got lvl=%b oh=%b p=%b want lvl=%b oh=%b p=%b", i,
                 key_level, key_onehot, key_pulse, m_level, m_onehot, m_pulse);
      end
      checks++;
      if ($countones(key_onehot) > 1) begin
        errors++;
        $display("FAIL random_onehot i=%0d: got %b want at most one bit", i, key_onehot);
      end
    end
    rst = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_clr_vs_press();
    test_repress();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scan4.md
Name: key_scan4

Overview:
- Upstream front end for the 4-input one-hot-to-binary encoder stage. It samples four raw push-buttons and produces the one-hot `I[3:0]` that stage consumes.
- Per-key processing chain:
  - 2-FF synchronise.
  - Counter-based debounce.
  - Rising-edge detect.
- Latches the most recently pressed key as a held one-hot code, with a one-cycle strobe.
- Guarantees at most one bit of `key_onehot` is set at any time.

Parameters:
- CNT_MAX, 2_000_000, consecutive stable cycles required before a level change is accepted (20 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(CNT_MAX+1), debounce counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- key_raw  input  4  asynchronous button levels, 1 = pressed.
- clr  input  1  synchronous clear of the latched key.
- key_level  output  4  debounced stable level per key.
- key_onehot  output  4  latched one-hot of last pressed key; 0000 = none; feeds the encoder `I`.
- key_pulse  output  1  one-cycle strobe on the cycle `key_onehot` is updated by a press.

Behaviour:
- Reset (rst=1 at posedge): sync flops, stable levels, counters, edge history, `key_onehot`, `key_pulse` all -> 0. Reset mid-debounce discards the count; no pulse is generated by reset release.
- Synchroniser: `s1 <= key_raw[i]`, `s2 <= s1`; only `s2` is used downstream.
- Debounce, per key, independent:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == CNT_MAX-1`: `stable <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any glitch back to the stable value restarts the count.
  - `key_level = stable`, registered.
- Edge detect: `rise[i] = stable[i] & ~stable_d[i]`, where `stable_d` is a 1-cycle delayed copy. Releases (1->0) update `key_level` only.
- Latch, registered on each posedge:
  - If any `rise`: `key_onehot` <= only the highest-index rising bit (priority 3>2>1>0) and `key_pulse` <= 1.
  - Else if `clr`: `key_onehot` <= 0000 and `key_pulse` <= 0.
  - Else: hold `key_onehot` and `key_pulse` <= 0.
  - Press beats simultaneous `clr`.
- Latency: if t0 is the first posedge sampling `key_raw[i]`=1 held steady:
  - `s2` = 1 after t0+1.
  - `key_level[i]` = 1 after edge t0+1+CNT_MAX.
  - `key_onehot` and `key_pulse` = 1 after edge t0+2+CNT_MAX.
- Boundaries:
  - A bounce shorter than CNT_MAX cycles never changes `key_level`.
  - Key held indefinitely gives exactly one pulse.
  - Second key pressed while the first is held: onehot switches to the new key with a new pulse.
  - Re-press of the same key: pulse again, onehot unchanged value.
  - Counter never exceeds CNT_MAX-1; no wrap.
- `key_onehot` is never multi-hot, so the downstream encoder default branch is unreachable.

Decomposition:
- Shared package:
  - `NKEY=4`.
  - Default `CNT_MAX` constant plus a simulation override value of 4.
- One natural sub-module: `key_debounce`, single-channel synchroniser + counter + stable register + rise output, parameterised by CNT_MAX. `key_scan4` instantiates 4 copies and holds the priority latch.

Test Plan (CNT_MAX=4 for all):
- Reset: assert rst 3 cycles with `key_raw`=1111 -> `key_level`=0000, `key_onehot`=0000, `key_pulse`=0; after release, keys held -> one pulse each debounce, `key_onehot`=1000.
- Clean press, key1 held from t0 -> `key_level`=0010 after t0+5, `key_onehot`=0010 and `key_pulse`=1 after t0+6 only, pulse 0 at t0+7.
- Bounce: key2 toggles 1,0,1,0 per cycle for 10 cycles, then 0 -> `key_level`/`key_onehot` stay 0000, no pulse.
- Simultaneous press: key0 and key3 rise on the same edge -> `key_onehot`=1000, single pulse. Then release key3 and press key2 -> `key_onehot`=0100 with a second pulse.
- Clear vs press: `clr`=1 on the same edge as key1's rise -> `key_onehot`=0010. `clr` next cycle -> 0000, no pulse.
- Release and re-press key0 -> release gives no pulse. Re-press gives a pulse with `key_onehot`=0001. Random 10k-cycle run: `key_onehot` never has more than one bit set (assertion).
